// File: rtl/mul_add_seq.sv
// -----------------------------------------------------------------------------
// mul_add_seq
//   Serial multiply-add: out_data = coef * x + addend. The engine walks one bit
//   of x per clock with a shift-add accumulator. It replaces the old fixed
//   combinational 5x+1 block: with the default widths, coef=5 and addend=1 it
//   reproduces that function. Overflow either wraps modulo 2^OUT_W (SAT=0) or
//   saturates to all-ones (SAT=1). out_ovf reports the overflow in both cases.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand set offered
//   in_ready   : block accepts operands (registered, high only in IDLE)
//   in_x       : multiplicand x, IN_W bits, unsigned
//   in_coef    : coefficient, K_W bits, unsigned
//   in_addend  : addend, OUT_W bits, unsigned
//   out_valid  : result available (registered, high in DONE)
//   out_ready  : consumer takes the result
//   out_data   : result, OUT_W bits, wrapped or saturated
//   out_ovf    : true result did not fit in OUT_W bits
//   busy       : operation in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module mul_add_seq #(
    parameter int IN_W  = 7,
    parameter int K_W   = 3,
    parameter int OUT_W = 10,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic [K_W-1:0]   in_coef,
    input  logic [OUT_W-1:0] in_addend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    // One spare bit above the widest term, so coef*x + addend cannot overflow.
    localparam int ACC_W = (((IN_W + K_W) > OUT_W) ? (IN_W + K_W) : OUT_W) + 1;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    if ((IN_W < 1) || (K_W < 1) || (OUT_W < 2)) begin : g_bad_params
        $error("mul_add_seq: illegal widths (need IN_W>=1, K_W>=1, OUT_W>=2)");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    x_sh_q, x_sh_d;       // x, shifted right so bit 0 is the current bit
    logic [ACC_W-1:0]   coef_sh_q, coef_sh_d; // coef << cnt, kept as a shifting register
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   acc_sum_s;
    logic               ovf_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        x_sh_d      = x_sh_q;
        coef_sh_d   = coef_sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        // Partial product for the current bit of x, folded into the accumulator.
        acc_sum_s = acc_q + (x_sh_q[0] ? coef_sh_q : {ACC_W{1'b0}});
        ovf_s     = |acc_sum_s[ACC_W-1:OUT_W];

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_sh_d    = in_x;
                    coef_sh_d = {{(ACC_W-K_W){1'b0}}, in_coef};
                    acc_d     = {{(ACC_W-OUT_W){1'b0}}, in_addend};
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d     = acc_sum_s;
                x_sh_d    = x_sh_q >> 1;
                coef_sh_d = coef_sh_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                // Every bit of x is visited, even when x or coef is zero.
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_DONE;
                    out_ovf_d  = ovf_s;
                    out_data_d = (SAT && ovf_s) ? {OUT_W{1'b1}} : acc_sum_s[OUT_W-1:0];
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs follow the next state, so they come straight from flops.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_sh_q      <= {IN_W{1'b0}};
            coef_sh_q   <= {ACC_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_sh_q      <= x_sh_d;
            coef_sh_q   <= coef_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_add_seq
//   Three instances of mul_add_seq: u_a has the default widths and wraps,
//   u_b has the default widths and saturates, and u_c is 12/8/16 and saturates.
//   Shared drivers feed all three, and 'sel' picks which one is active.
//   The expected result is queued when an operand set is offered. A monitor
//   pops it on each output handshake and checks data, ovf and the latency
//   from the accepting edge to the out_valid rise.
// -----------------------------------------------------------------------------
module tb_mul_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_x;
    logic [7:0]  in_coef;
    logic [15:0] in_addend;
    logic        out_ready;
    logic        or_man;
    logic        rnd_mode;
    int          sel;

    logic        a_ir, a_ov, a_ovf, a_busy;
    logic [9:0]  a_d;
    logic        b_ir, b_ov, b_ovf, b_busy;
    logic [9:0]  b_d;
    logic        c_ir, c_ov, c_ovf, c_busy;
    logic [15:0] c_d;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [15:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int exp_d_q[$];
    int exp_o_q[$];
    int acc_q[$];

    typedef struct {
        int sel;
        int x;
        int c;
        int a;
        int ed;
        int eo;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_add_seq u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 0)), .in_ready(a_ir),
        .in_x(in_x[6:0]), .in_coef(in_coef[2:0]), .in_addend(in_addend[9:0]),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_d), .out_ovf(a_ovf), .busy(a_busy)
    );

    mul_add_seq #(.SAT(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 1)), .in_ready(b_ir),
        .in_x(in_x[6:0]), .in_coef(in_coef[2:0]), .in_addend(in_addend[9:0]),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_d), .out_ovf(b_ovf), .busy(b_busy)
    );

    mul_add_seq #(.IN_W(12), .K_W(8), .OUT_W(16), .SAT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2)), .in_ready(c_ir),
        .in_x(in_x), .in_coef(in_coef), .in_addend(in_addend),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_d), .out_ovf(c_ovf), .busy(c_busy)
    );

    // View of the selected instance.
    always_comb begin
        in_ready  = a_ir;
        out_valid = a_ov;
        out_ovf   = a_ovf;
        busy      = a_busy;
        out_data  = {6'd0, a_d};
        case (sel)
            1: begin
                in_ready = b_ir; out_valid = b_ov; out_ovf = b_ovf; busy = b_busy; out_data = {6'd0, b_d};
            end
            2: begin
                in_ready = c_ir; out_valid = c_ov; out_ovf = c_ovf; busy = c_busy; out_data = c_d;
            end
            default: begin
                in_ready = a_ir;
            end
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // out_ready: manual value or random, changed 2 time units after the edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : or_man;
        end
    end

    // Monitor and scoreboard.
    initial begin : mon
        logic prev_ov;
        int   e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
                    else begin
                        e = acc_q.pop_front();
                        chk("latency", cyc - e, (sel == 2) ? 12 : 7);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_d_q.size() == 0) chk("unexpected_result", 1, 0);
                    else begin
                        chk("out_data", out_data, exp_d_q.pop_front());
                        chk("out_ovf", out_ovf, exp_o_q.pop_front());
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // Offer one operand set and queue its expected result; return after it is accepted.
    task automatic send(input int x, input int c, input int a, input int ed, input int eo);
        int n;
        in_x      = 12'(x);
        in_coef   = 8'(c);
        in_addend = 16'(a);
        in_valid  = 1'b1;
        exp_d_q.push_back(ed);
        exp_o_q.push_back(eo);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every queued result has come out.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_d_q.size() > 0) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_d_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : wdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, x, c, a, s;
        rst_n = 1'b1; in_valid = 1'b0; in_x = 12'd0; in_coef = 8'd0; in_addend = 16'd0;
        sel = 0; or_man = 1'b1; rnd_mode = 1'b0;

        for (int i = 0; i < 128; i++) tbl.push_back('{0, i, 5, 1, 5 * i + 1, 0});
        tbl.push_back('{0, 127, 7, 200, 65, 1});
        tbl.push_back('{0, 0, 7, 1023, 1023, 0});
        tbl.push_back('{0, 127, 0, 5, 5, 0});
        tbl.push_back('{0, 1, 1, 1023, 0, 1});
        tbl.push_back('{1, 127, 7, 200, 1023, 1});
        tbl.push_back('{1, 1, 1, 1023, 1023, 1});
        tbl.push_back('{1, 3, 2, 0, 6, 0});
        tbl.push_back('{1, 0, 0, 9, 9, 0});

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].sel != sel) begin
                drain();
                sel = tbl[i].sel;
            end
            send(tbl[i].x, tbl[i].c, tbl[i].a, tbl[i].ed, tbl[i].eo);
        end
        drain();

        // Backpressure: result held while new operands are offered and ignored.
        sel = 0;
        or_man = 1'b0;
        @(posedge clk);
        #1;
        send(3, 5, 1, 16, 0);
        n = 0;
        while (!out_valid && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        in_x = 12'd9; in_coef = 8'd2; in_addend = 16'd0; in_valid = 1'b1;
        exp_d_q.push_back(18);
        exp_o_q.push_back(0);
        repeat (20) begin
            @(negedge clk);
            chk("bp_data_held", out_data, 16);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        or_man = 1'b1;
        @(posedge clk);
        #1;
        or_man = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("bp_next_accepted", busy, 1);
        in_valid = 1'b0;
        or_man = 1'b1;
        drain();

        // Reset in the middle of RUN: no result, then a clean operation.
        send(100, 3, 0, 300, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_ovf", out_ovf, 0);
        exp_d_q.delete();
        exp_o_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", in_ready, 1);
        repeat (15) begin
            @(negedge clk);
            chk("mid_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2, 3, 4, 10, 0);
        drain();

        // Wide saturating instance, random operands and random out_ready.
        sel = 2;
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = int'($urandom_range(0, 4095));
            c = int'($urandom_range(0, 255));
            a = int'($urandom_range(0, 65535));
            s = x * c + a;
            send(x, c, a, (s > 65535) ? 65535 : s, (s > 65535) ? 1 : 0);
        end
        drain();
        rnd_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
